// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: display driver bus.
//   master: drives en, mode, data, dp_in, blink_mask, load; observes seg, dp, sel, led, frame_tick.
//   slave:  the display driver side.
interface seg_scan_display_if #(parameter int N_DIGITS = 4);
  logic                    en;
  logic [1:0]              mode;
  logic [4*N_DIGITS-1:0]   data;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     blink_mask;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [N_DIGITS-1:0]     sel;
  logic                    led;
  logic                    frame_tick;
  modport master (output en, mode, data, dp_in, blink_mask, load,
                  input seg, dp, sel, led, frame_tick);
  modport slave  (input en, mode, data, dp_in, blink_mask, load,
                  output seg, dp, sel, led, frame_tick);
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-cathode 7-segment driver.
//   clk, rst_n (async, active low)
//   bus.en/mode/data/dp_in/blink_mask/load in; bus.seg/dp/sel/led/frame_tick out.
//   Display contents only change at frame boundaries; outputs lag idx by one cycle.
module seg_scan_display #(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_display_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [DW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic [4*N_DIGITS-1:0] pend_data, disp_data;
  logic [N_DIGITS-1:0]   pend_dp, pend_blink, disp_dp, disp_blink;
  logic                  pend_vld;
  logic                  slot_tick, wrap;
  logic [3:0]            nib;
  logic [N_DIGITS-1:0]   lz;
  logic                  lz_blank, blink_blank;
  logic [6:0]            seg_dec;
  assign slot_tick   = div_cnt == DW'(CLK_DIV - 1);
  assign wrap        = slot_tick && idx == IW'(N_DIGITS - 1);
  assign nib         = disp_data[{idx, 2'b00} +: 4];
  assign lz_blank    = bus.mode == 2'b00 && idx != '0 && lz[idx];
  assign blink_blank = blink_phase && disp_blink[idx];
  // lz[i]: every nibble from the top digit down to digit i is zero
  always_comb begin
    lz = '0;
    lz[N_DIGITS-1] = disp_data[4*N_DIGITS-1 -: 4] == 4'd0;
    for (int i = N_DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] && disp_data[4*i +: 4] == 4'd0;
  end
  always_comb begin
    seg_dec = 7'h00;
    case (nib)
      4'h0: seg_dec = 7'h7E;
      4'h1: seg_dec = 7'h30;
      4'h2: seg_dec = 7'h6D;
      4'h3: seg_dec = 7'h79;
      4'h4: seg_dec = 7'h33;
      4'h5: seg_dec = 7'h5B;
      4'h6: seg_dec = 7'h5F;
      4'h7: seg_dec = 7'h70;
      4'h8: seg_dec = 7'h7F;
      4'h9: seg_dec = 7'h7B;
      4'hA: seg_dec = 7'h77;
      4'hB: seg_dec = 7'h1F;
      4'hC: seg_dec = 7'h4E;
      4'hD: seg_dec = 7'h3D;
      4'hE: seg_dec = 7'h4F;
      default: seg_dec = 7'h47;
    endcase
    if (nib > 4'd9 && bus.mode != 2'b11) seg_dec = bus.mode == 2'b10 ? 7'h7F : 7'h00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt        <= '0;
      idx            <= '0;
      frame_cnt      <= '0;
      blink_phase    <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      div_cnt        <= slot_tick ? '0 : div_cnt + DW'(1);
      idx            <= wrap ? '0 : slot_tick ? idx + IW'(1) : idx;
      bus.frame_tick <= wrap;
      if (bus.frame_tick) begin
        frame_cnt   <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + FW'(1);
        blink_phase <= blink_phase ^ (frame_cnt == FW'(BLINK_FRAMES - 1));
      end
    end
  end
  // A load landing on the boundary cycle bypasses the pending stage entirely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
      pend_vld   <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blink <= '0;
    end else begin
      if (bus.load) begin
        pend_data  <= bus.data;
        pend_dp    <= bus.dp_in;
        pend_blink <= bus.blink_mask;
      end
      if (wrap) begin
        pend_vld <= 1'b0;
        if (bus.load) begin
          disp_data  <= bus.data;
          disp_dp    <= bus.dp_in;
          disp_blink <= bus.blink_mask;
        end else if (pend_vld) begin
          disp_data  <= pend_data;
          disp_dp    <= pend_dp;
          disp_blink <= pend_blink;
        end
      end else if (bus.load) begin
        pend_vld <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg <= 7'h00;
      bus.dp  <= 1'b0;
      bus.sel <= '1;
      bus.led <= 1'b1;
    end else begin
      bus.seg <= bus.en && !blink_blank && !lz_blank ? seg_dec : 7'h00;
      bus.dp  <= bus.en && !blink_blank && disp_dp[idx];
      bus.sel <= bus.en ? ~(N_DIGITS'(1) << idx) : '1;
      bus.led <= bus.mode != 2'b11;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed self-checking bench for seg_scan_display (N=4, CLK_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [6:0] cs[4];
  logic       cd[4];
  logic [3:0] csel[4];
  logic       cok;
  seg_scan_display_if #(.N_DIGITS(4)) bus ();
  seg_scan_display #(.N_DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    @(negedge clk);
    bus.data = d;
    bus.dp_in = p;
    bus.blink_mask = b;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic wait_tick(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  // samples digit d of the next frame at tick+1+4d, ending 3 cycles before the following tick
  task automatic capture();
    wait_tick(cok);
    for (int d = 0; d < 4; d++) begin
      if (d != 0) repeat (3) @(negedge clk);
      @(negedge clk);
      cs[d] = bus.seg;
      cd[d] = bus.dp;
      csel[d] = bus.sel;
    end
  endtask
  task automatic test_reset();
    logic [15:0] exp_data;
    exp_data = 16'h1234;
    do_load(exp_data, 4'h0, 4'h0);
    repeat (20) @(negedge clk);
    checks++;
    if (bus.led !== 1'b0) begin failures++; $display("FAIL pre_reset_led got=%b exp=0", bus.led); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.seg !== 7'h00) begin failures++; $display("FAIL rst_seg got=%h exp=00", bus.seg); end
    checks++;
    if (bus.sel !== 4'b1111) begin failures++; $display("FAIL rst_sel got=%b exp=1111", bus.sel); end
    checks++;
    if (bus.led !== 1'b1 || bus.dp !== 1'b0 || bus.frame_tick !== 1'b0) begin
      failures++; $display("FAIL rst_misc got led=%b dp=%b ft=%b exp 1 0 0", bus.led, bus.dp, bus.frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_scan();
    logic [6:0] es[4] = '{7'h7E, 7'h79, 7'h77, 7'h47};
    logic       ed[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] el[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] wsel;
    bus.mode = 2'b11;
    do_load(16'hFA30, 4'b0100, 4'b0000);
    capture();
    checks++;
    if (!cok) begin failures++; $display("FAIL scan_tick timeout got=0 exp=1"); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cs[d] !== es[d] || cd[d] !== ed[d] || csel[d] !== el[d]) begin
        failures++;
        $display("FAIL scan_digit%0d got seg=%h dp=%b sel=%b exp seg=%h dp=%b sel=%b", d, cs[d], cd[d], csel[d], es[d], ed[d], el[d]);
      end
    end
    wait_tick(cok);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      wsel = el[(k-1)/4];
      checks++;
      if (bus.sel !== wsel) begin failures++; $display("FAIL scan_walk k=%0d got=%b exp=%b", k, bus.sel, wsel); end
    end
    checks++;
    if (bus.led !== 1'b0) begin failures++; $display("FAIL scan_led got=%b exp=0", bus.led); end
  endtask
  task automatic test_lz();
    logic [6:0] e1[4] = '{7'h7E, 7'h5B, 7'h00, 7'h00};
    bus.mode = 2'b00;
    do_load(16'h0050, 4'b0000, 4'b0000);
    capture();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cs[d] !== e1[d]) begin failures++; $display("FAIL lz_0050_d%0d got=%h exp=%h", d, cs[d], e1[d]); end
    end
    do_load(16'h0000, 4'b0000, 4'b0000);
    capture();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cs[d] !== (d == 0 ? 7'h7E : 7'h00)) begin
        failures++; $display("FAIL lz_0000_d%0d got=%h exp=%h", d, cs[d], (d == 0 ? 7'h7E : 7'h00));
      end
    end
  endtask
  task automatic test_modes();
    logic [1:0] ms[3] = '{2'b10, 2'b01, 2'b11};
    logic [6:0] es[3] = '{7'h7F, 7'h00, 7'h4E};
    logic       el[3] = '{1'b1, 1'b1, 1'b0};
    do_load(16'h000C, 4'b0000, 4'b0000);
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      bus.mode = ms[m];
      capture();
      checks++;
      if (cs[0] !== es[m]) begin failures++; $display("FAIL mode%b_seg got=%h exp=%h", ms[m], cs[0], es[m]); end
      checks++;
      if (bus.led !== el[m]) begin failures++; $display("FAIL mode%b_led got=%b exp=%b", ms[m], bus.led, el[m]); end
    end
  endtask
  task automatic test_back_to_back();
    bus.mode = 2'b11;
    do_load(16'h1111, 4'b0000, 4'b0000);
    capture();
    wait_tick(cok);
    bus.data = 16'h2222;
    bus.load = 1'b1;
    @(negedge clk);
    bus.data = 16'h3333;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (bus.seg !== 7'h30 || bus.sel !== 4'b0111) begin
      failures++; $display("FAIL b2b_hold got seg=%h sel=%b exp seg=30 sel=0111", bus.seg, bus.sel);
    end
    wait_tick(cok);
    @(negedge clk);
    checks++;
    if (bus.seg !== 7'h79) begin failures++; $display("FAIL b2b_last_wins got=%h exp=79", bus.seg); end
    repeat (14) @(negedge clk);
    bus.data = 16'h8888;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    checks++;
    if (bus.frame_tick !== 1'b1) begin failures++; $display("FAIL boundary_align got=%b exp=1", bus.frame_tick); end
    @(negedge clk);
    checks++;
    if (bus.seg !== 7'h7F) begin failures++; $display("FAIL boundary_load got=%h exp=7F", bus.seg); end
  endtask
  task automatic test_blink_en();
    logic eb[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load(16'h1234, 4'b0010, 4'b0010);
    for (int f = 1; f <= 5; f++) begin
      capture();
      checks++;
      if (cs[1] !== (eb[f] ? 7'h00 : 7'h79) || cd[1] !== !eb[f] || csel[1] !== 4'b1101) begin
        failures++;
        $display("FAIL blink_f%0d got seg=%h dp=%b sel=%b exp seg=%h dp=%b sel=1101", f, cs[1], cd[1], csel[1], (eb[f] ? 7'h00 : 7'h79), !eb[f]);
      end
      checks++;
      if (cs[0] !== 7'h33) begin failures++; $display("FAIL blink_d0_f%0d got=%h exp=33", f, cs[0]); end
    end
    wait_tick(cok);
    bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sel !== 4'b1111 || bus.seg !== 7'h00 || bus.dp !== 1'b0) begin
      failures++; $display("FAIL en_off got sel=%b seg=%h dp=%b exp 1111 00 0", bus.sel, bus.seg, bus.dp);
    end
    wait_tick(cok);
    checks++;
    if (!cok || bus.sel !== 4'b1111) begin failures++; $display("FAIL en_off_tick got tick=%b sel=%b exp 1 1111", cok, bus.sel); end
    bus.en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sel !== 4'b1110 || bus.seg !== 7'h33) begin
      failures++; $display("FAIL en_resume got sel=%b seg=%h exp 1110 33", bus.sel, bus.seg);
    end
  endtask
  initial begin
    bus.en = 1'b1;
    bus.mode = 2'b11;
    bus.data = '0;
    bus.dp_in = '0;
    bus.blink_mask = '0;
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.sel !== 4'b1111 || bus.seg !== 7'h00 || bus.led !== 1'b1) begin
      failures++; $display("FAIL init_reset got sel=%b seg=%h led=%b exp 1111 00 1", bus.sel, bus.seg, bus.led);
    end
    rst_n = 1'b1;
    test_reset();
    test_scan();
    test_lz();
    test_modes();
    test_back_to_back();
    test_blink_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
